// File: rtl/rsb_spec.sv
// Return stack buffer: circular return-address stack with checkpoint/restore for
// mispredict recovery. Priority is flush > restore > push/pop/ckpt.
module rsb_spec #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 64,
  parameter int NCKPT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [ADDR_W-1:0]        push_addr_i,
  input  logic                     pop_i,
  input  logic                     ckpt_i,
  input  logic [$clog2(NCKPT)-1:0] ckpt_id_i,
  input  logic                     restore_i,
  input  logic [$clog2(NCKPT)-1:0] restore_id_i,
  input  logic                     flush_i,
  output logic [ADDR_W-1:0]        top_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  output logic                     restore_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] r_stack [DEPTH];
  logic [AW-1:0]     r_sp;
  logic [CW-1:0]     r_count;

  logic [AW-1:0]     r_ck_sp  [NCKPT];
  logic [CW-1:0]     r_ck_cnt [NCKPT];
  logic [ADDR_W-1:0] r_ck_top [NCKPT];
  logic [NCKPT-1:0]  r_ck_vld;

  logic              w_empty, w_full;
  logic [AW-1:0]     w_spm1, w_rs_sp, w_rs_spm1;
  logic [CW-1:0]     w_rs_cnt;
  logic [ADDR_W-1:0] w_top;
  logic              w_rs_hit, w_do_rs, w_pp;
  logic              w_wr_en;
  logic [AW-1:0]     w_wr_idx;
  logic [ADDR_W-1:0] w_wr_data;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL);
  assign w_spm1    = r_sp - 1'b1;
  assign w_top     = w_empty ? '0 : r_stack[w_spm1];
  assign w_rs_sp   = r_ck_sp[restore_id_i];
  assign w_rs_spm1 = w_rs_sp - 1'b1;
  assign w_rs_cnt  = r_ck_cnt[restore_id_i];

  // A valid restore wins over push/pop; an invalid one lets them through.
  assign w_rs_hit = restore_i && r_ck_vld[restore_id_i];
  assign w_do_rs  = !flush_i && w_rs_hit;
  assign w_pp     = !flush_i && !w_rs_hit;

  assign top_o         = w_top;
  assign valid_o       = !w_empty;
  assign count_o       = r_count;
  assign overflow_o    = !rst && w_pp && push_i && !pop_i && w_full;
  assign underflow_o   = !rst && w_pp && pop_i && w_empty;
  assign restore_err_o = !rst && !flush_i && restore_i && !r_ck_vld[restore_id_i];

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = r_sp;
    w_wr_data = push_addr_i;
    if (w_do_rs) begin
      w_wr_en   = (w_rs_cnt != '0);
      w_wr_idx  = w_rs_spm1;
      w_wr_data = r_ck_top[restore_id_i];
    end else if (w_pp && push_i) begin
      w_wr_en  = 1'b1;
      // push+pop on a non-empty stack replaces the top in place
      w_wr_idx = (pop_i && !w_empty) ? w_spm1 : r_sp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp     <= '0;
      r_count  <= '0;
      r_ck_vld <= '0;
    end else if (flush_i) begin
      r_sp     <= '0;
      r_count  <= '0;
      r_ck_vld <= '0;
    end else if (w_do_rs) begin
      r_sp    <= w_rs_sp;
      r_count <= w_rs_cnt;
    end else begin
      if (ckpt_i) r_ck_vld[ckpt_id_i] <= 1'b1;
      if (push_i && !(pop_i && !w_empty)) begin
        r_sp    <= r_sp + 1'b1;
        r_count <= w_full ? r_count : r_count + 1'b1;
      end else if (pop_i && !push_i && !w_empty) begin
        r_sp    <= w_spm1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Payload storage carries no reset; it is never visible while count is zero.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_stack[w_wr_idx] <= w_wr_data;
    if (w_pp && ckpt_i) begin
      r_ck_sp[ckpt_id_i]  <= r_sp;
      r_ck_cnt[ckpt_id_i] <= r_count;
      r_ck_top[ckpt_id_i] <= w_top;
    end
  end
endmodule

// File: tb/tb_rsb_spec.sv
// Directed vector bench for rsb_spec at DEPTH=4, ADDR_W=16, NCKPT=4.
module tb_rsb_spec;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_i = 1'b0, pop_i = 1'b0, ckpt_i = 1'b0, restore_i = 1'b0, flush_i = 1'b0;
  logic [15:0] push_addr_i = '0;
  logic [1:0]  ckpt_id_i = '0, restore_id_i = '0;
  logic [15:0] top_o;
  logic        valid_o, overflow_o, underflow_o, restore_err_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  rsb_spec #(.DEPTH(4), .ADDR_W(16), .NCKPT(4)) dut (
    .clk(clk), .rst(rst), .push_i(push_i), .push_addr_i(push_addr_i), .pop_i(pop_i),
    .ckpt_i(ckpt_i), .ckpt_id_i(ckpt_id_i), .restore_i(restore_i),
    .restore_id_i(restore_id_i), .flush_i(flush_i), .top_o(top_o), .valid_o(valid_o),
    .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .restore_err_o(restore_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [15:0] addr;
    logic        pop;
    logic        ck;
    logic [1:0]  ckid;
    logic        rs;
    logic [1:0]  rid;
    logic        fl;
    logic [15:0] top;
    logic [2:0]  cnt;
    logic        ovf, unf, rerr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic pu, logic [15:0] a, logic po, logic c, logic [1:0] cid,
                              logic r, logic [1:0] rid, logic f, logic [15:0] t,
                              logic [2:0] n, logic ov, logic un, logic re);
    vec_t v;
    v.push = pu; v.addr = a; v.pop = po; v.ck = c; v.ckid = cid; v.rs = r; v.rid = rid;
    v.fl = f; v.top = t; v.cnt = n; v.ovf = ov; v.unf = un; v.rerr = re;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    push_i = 0; pop_i = 0; ckpt_i = 0; restore_i = 0; flush_i = 0;
  endtask

  initial begin
    //                   pu addr    po ck id rs id fl   top     cnt ov un re
    tv.push_back(mk(1, 16'h00A1, 0, 0, 0, 0, 0, 0, 16'h00A1, 1, 0, 0, 0));
    tv.push_back(mk(1, 16'h00A2, 0, 0, 0, 0, 0, 0, 16'h00A2, 2, 0, 0, 0));
    tv.push_back(mk(1, 16'h00A3, 0, 0, 0, 0, 0, 0, 16'h00A3, 3, 0, 0, 0));
    tv.push_back(mk(1, 16'h00A4, 0, 0, 0, 0, 0, 0, 16'h00A4, 4, 0, 0, 0));
    tv.push_back(mk(1, 16'h00A5, 0, 0, 0, 0, 0, 0, 16'h00A5, 4, 1, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h00A4, 3, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h00A3, 2, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h00A2, 1, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0));
    tv.push_back(mk(1, 16'h0077, 1, 0, 0, 0, 0, 0, 16'h0077, 1, 0, 1, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    // push+pop replaces top
    tv.push_back(mk(1, 16'h00A1, 0, 0, 0, 0, 0, 0, 16'h00A1, 1, 0, 0, 0));
    tv.push_back(mk(1, 16'h00A2, 0, 0, 0, 0, 0, 0, 16'h00A2, 2, 0, 0, 0));
    tv.push_back(mk(1, 16'h00B0, 1, 0, 0, 0, 0, 0, 16'h00B0, 2, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h00A1, 1, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    // ckpt 3, pop, pop, push C, restore 3; C clobbered the deeper entry, only top is saved
    tv.push_back(mk(1, 16'h00A1, 0, 0, 0, 0, 0, 0, 16'h00A1, 1, 0, 0, 0));
    tv.push_back(mk(1, 16'h00A2, 0, 0, 0, 0, 0, 0, 16'h00A2, 2, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 1, 3, 0, 0, 0, 16'h00A2, 2, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h00A1, 1, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tv.push_back(mk(1, 16'h00C0, 0, 0, 0, 0, 0, 0, 16'h00C0, 1, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 3, 0, 16'h00A2, 2, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h00C0, 1, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    // ckpt 2, pop, push C, restore 2 -> deeper entry intact
    tv.push_back(mk(1, 16'h00A1, 0, 0, 0, 0, 0, 0, 16'h00A1, 1, 0, 0, 0));
    tv.push_back(mk(1, 16'h00A2, 0, 0, 0, 0, 0, 0, 16'h00A2, 2, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 1, 2, 0, 0, 0, 16'h00A2, 2, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h00A1, 1, 0, 0, 0));
    tv.push_back(mk(1, 16'h00C0, 0, 0, 0, 0, 0, 0, 16'h00C0, 2, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 2, 0, 16'h00A2, 2, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h00A1, 1, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 3, 0, 16'h00A2, 2, 0, 0, 0));
    // invalid restore with push D
    tv.push_back(mk(1, 16'h00D0, 0, 0, 0, 1, 1, 0, 16'h00D0, 3, 0, 0, 1));
    // ckpt with same-cycle push, then restore suppresses a would-be overflow
    tv.push_back(mk(1, 16'h00E0, 0, 1, 0, 0, 0, 0, 16'h00E0, 4, 0, 0, 0));
    tv.push_back(mk(1, 16'h0099, 0, 0, 0, 1, 0, 0, 16'h00D0, 3, 0, 0, 0));
    // flush beats restore and push; later restores are invalid
    tv.push_back(mk(1, 16'h0055, 0, 0, 0, 1, 0, 1, 16'h0000, 0, 0, 0, 0));
    tv.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 1));
    tv.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 3, 0, 16'h0000, 0, 0, 0, 1));
    tv.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0));

    // reset state, with a pop held so a gated underflow would show
    pop_i = 1'b1;
    #3;
    chk("rst_top", 32'(top_o), 0);
    chk("rst_cnt", 32'(count_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_flags", {29'd0, overflow_o, underflow_o, restore_err_o}, 0);
    @(negedge clk); idle(); rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      push_i = tv[i].push; push_addr_i = tv[i].addr; pop_i = tv[i].pop;
      ckpt_i = tv[i].ck; ckpt_id_i = tv[i].ckid; restore_i = tv[i].rs;
      restore_id_i = tv[i].rid; flush_i = tv[i].fl;
      #1;
      chk($sformatf("v%0d_ovf", i), 32'(overflow_o), 32'(tv[i].ovf));
      chk($sformatf("v%0d_unf", i), 32'(underflow_o), 32'(tv[i].unf));
      chk($sformatf("v%0d_rerr", i), 32'(restore_err_o), 32'(tv[i].rerr));
      @(posedge clk); #1;
      chk($sformatf("v%0d_top", i), 32'(top_o), 32'(tv[i].top));
      chk($sformatf("v%0d_cnt", i), 32'(count_o), 32'(tv[i].cnt));
      chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(tv[i].cnt != 0));
    end

    // async reset mid-push
    @(negedge clk); idle();
    push_i = 1; push_addr_i = 16'h0011;
    @(negedge clk); push_addr_i = 16'h0022;
    @(negedge clk); push_addr_i = 16'h1234;
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(count_o), 0);
    chk("arst_top", 32'(top_o), 0);
    chk("arst_valid", 32'(valid_o), 0);
    @(posedge clk); #1;
    chk("arst_hold_cnt", 32'(count_o), 0);
    @(negedge clk); idle(); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cnt", 32'(count_o), 0);
    chk("post_rst_top", 32'(top_o), 0);
    @(negedge clk); restore_i = 1; restore_id_i = 2'd0;
    #1 chk("post_rst_rerr", 32'(restore_err_o), 1);
    @(negedge clk); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
